// File: rtl/song_reader.sv
// Song sequencer: walks the note ROM of the selected song forwards or backwards and
// hands each entry to the note player. Optional looping build: define SONG_READER_REPEAT_EN.
module song_reader #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6,
  parameter int IDX_W  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      play,
  input  logic [1:0]                song,
  input  logic                      backwards,
  input  logic                      reset_player,
  output logic [IDX_W+1:0]          rom_addr,
  input  logic [NOTE_W+DUR_W-1:0]   rom_data,
  output logic [NOTE_W-1:0]         note,
  output logic [DUR_W-1:0]          duration,
  output logic                      new_note,
  input  logic                      note_done,
  output logic                      song_done
);

`ifdef SONG_READER_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_WAIT_ROM  = 3'd2;
  localparam logic [2:0] S_ISSUE     = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  logic [2:0]        r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [1:0]        r_song;
  logic              r_bwd;
  logic [NOTE_W-1:0] r_note;
  logic [DUR_W-1:0]  r_duration;
  logic              r_new_note;
  logic              r_song_done;

  logic [2:0]        w_state_nx;
  logic [IDX_W-1:0]  w_idx_nx;
  logic              w_sample;
  logic              w_load;
  logic              w_end;
  logic              w_done_pulse;

  logic [DUR_W-1:0]  w_dur;
  logic [NOTE_W-1:0] w_note;
  logic [IDX_W-1:0]  w_start;
  logic [IDX_W-1:0]  w_start_in;
  logic              w_at_last;

  assign w_dur      = rom_data[DUR_W-1:0];
  assign w_note     = rom_data[NOTE_W+DUR_W-1:DUR_W];
  // All-ones index when reading backwards, zero otherwise.
  assign w_start    = {IDX_W{r_bwd}};
  assign w_start_in = {IDX_W{backwards}};
  assign w_at_last  = r_bwd ? (r_idx == '0) : (r_idx == '1);

  always_comb begin
    w_state_nx   = r_state;
    w_idx_nx     = r_idx;
    w_sample     = 1'b0;
    w_load       = 1'b0;
    w_end        = 1'b0;
    w_done_pulse = 1'b0;
    if (reset_player) begin
      w_state_nx = S_FETCH;
      w_idx_nx   = w_start_in;
      w_sample   = 1'b1;
    end else if (play) begin
      case (r_state)
        S_IDLE: begin
          w_state_nx = S_FETCH;
          w_idx_nx   = w_start_in;
          w_sample   = 1'b1;
        end
        S_FETCH:    w_state_nx = S_WAIT_ROM;
        S_WAIT_ROM: w_state_nx = S_ISSUE;
        S_ISSUE: begin
          if (w_dur != '0) begin
            w_load     = 1'b1;
            w_state_nx = S_WAIT_DONE;
          end else if (r_bwd && (r_idx != '0)) begin
            // Zero-duration entries at the top of a backward song are padding.
            w_idx_nx   = r_idx - IDX_W'(1);
            w_state_nx = S_FETCH;
          end else begin
            w_end = 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (note_done) begin
            if (w_at_last) begin
              w_end = 1'b1;
            end else begin
              w_idx_nx   = r_bwd ? (r_idx - IDX_W'(1)) : (r_idx + IDX_W'(1));
              w_state_nx = S_FETCH;
            end
          end
        end
        S_DONE:  w_state_nx = S_DONE;
        default: w_state_nx = S_IDLE;
      endcase
      if (w_end) begin
        if (REPEAT) begin
          w_state_nx = S_FETCH;
          w_idx_nx   = w_start;
        end else begin
          w_state_nx   = S_DONE;
          w_done_pulse = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_song      <= '0;
      r_bwd       <= 1'b0;
      r_note      <= '0;
      r_duration  <= '0;
      r_new_note  <= 1'b0;
      r_song_done <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_idx       <= w_idx_nx;
      r_new_note  <= w_load;
      r_song_done <= w_done_pulse;
      if (w_sample) begin
        r_song <= song;
        r_bwd  <= backwards;
      end
      if (w_load) begin
        r_note     <= w_note;
        r_duration <= w_dur;
      end
    end
  end

  assign rom_addr  = {r_song, r_idx};
  assign note      = r_note;
  assign duration  = r_duration;
  assign new_note  = r_new_note;
  assign song_done = r_song_done;

endmodule
